// File: rtl/picomem_pkg.sv
// picomem_pkg: shared widths, FSM state encoding and helpers for the
// picorv32 native-bus crossbar (picomem_xbar and its address decoder).
package picomem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned ECNT_W = 8;

    // Read data returned on every error response unless overridden.
    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESP     = 2'd2,
        RESP_ERR = 2'd3
    } state_t;

    // Saturating increment for the error counter.
    function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
        return (v == {ECNT_W{1'b1}}) ? v : v + ECNT_W'(1);
    endfunction

endpackage

// File: rtl/picomem_addr_decode.sv
// picomem_addr_decode: combinational priority address matcher.
// Slave i matches when (addr & mask_i) == base_i; lowest index wins on overlap.
// Ports:
//   addr      in   ADDR_W    master byte address
//   hit       out  N_SLAVES  one-hot winning slave (all zero when unmapped)
//   no_match  out  1         no window matched
module picomem_addr_decode
    import picomem_pkg::*;
#(
    parameter int unsigned                N_SLAVES = 4,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [N_SLAVES-1:0] hit,
    output logic                no_match
);

    // Scan from the top index down so a lower-index match overwrites a higher one.
    always_comb begin
        hit = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[ADDR_W*i +: ADDR_W]) == SLV_BASE[ADDR_W*i +: ADDR_W]) begin
                hit = N_SLAVES'(1) << i;
            end
        end
        no_match = (hit == '0);
    end

endmodule

// File: rtl/picomem_xbar.sv
// picomem_xbar: 1-master / N-slave interconnect for the picorv32 native bus.
// Registered one-hot select, single outstanding transaction, error response
// with latched fault address on unmapped access or slave timeout.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   m_valid/m_addr/m_wdata/m_wstrb master request (held until m_ready)
//   m_ready/m_rdata               registered one-cycle completion + read data
//   s_valid                       registered one-hot slave request
//   s_addr/s_wdata/s_wstrb        combinational broadcast of master request
//   s_ready/s_rdata               per-slave completion and read data
//   err_pulse/err_addr/err_count  error pulse, last fault address, saturating count
module picomem_xbar
    import picomem_pkg::*;
#(
    parameter int unsigned                N_SLAVES       = 4,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE       = {32'h0200_4000, 32'h0200_0000,
                                                            32'h0000_2000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK       = {32'hFFFF_FFF0, 32'hFFFF_FFFC,
                                                            32'hFFFF_FC00, 32'hFFFF_E000},
    parameter int unsigned                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]          ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [STRB_W-1:0]          m_wstrb,
    output logic                       m_ready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [N_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W-1:0]          s_wstrb,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    output logic                       err_pulse,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [ECNT_W-1:0]          err_count
);

    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    // Counter value in the last permitted ACCESS cycle (unused when disabled).
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nx;
    logic [N_SLAVES-1:0]   sel, sel_nx;
    logic [N_SLAVES-1:0]   s_valid_nx;
    logic                  m_ready_nx;
    logic [DATA_W-1:0]     m_rdata_nx;
    logic                  err_pulse_nx;
    logic [ADDR_W-1:0]     err_addr_nx;
    logic [ECNT_W-1:0]     err_count_nx;
    logic [CNT_W-1:0]      to_cnt, to_cnt_nx;

    logic [N_SLAVES-1:0]   hit;
    logic                  no_match;
    logic [DATA_W-1:0]     rdata_sel;
    logic                  sel_ready;

    // Request fields go straight through; only s_valid qualifies them.
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    picomem_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr     (m_addr),
        .hit      (hit),
        .no_match (no_match)
    );

    // One-hot AND-OR mux of the selected slave's read data.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (sel[i]) begin
                rdata_sel = rdata_sel | s_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready from slaves other than the selected one is ignored.
    assign sel_ready = |(s_ready & sel);

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        s_valid_nx   = '0;
        m_ready_nx   = 1'b0;
        m_rdata_nx   = m_rdata;
        err_pulse_nx = 1'b0;
        err_addr_nx  = err_addr;
        err_count_nx = err_count;
        to_cnt_nx    = '0;

        unique case (state)
            IDLE: begin
                if (m_valid) begin
                    if (no_match) begin
                        err_addr_nx  = m_addr;
                        m_ready_nx   = 1'b1;
                        m_rdata_nx   = ERR_RDATA;
                        err_pulse_nx = 1'b1;
                        err_count_nx = sat_inc(err_count);
                        state_nx     = RESP_ERR;
                    end else begin
                        sel_nx     = hit;
                        s_valid_nx = hit;
                        state_nx   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    // Captured for writes as well; the master ignores it then.
                    m_rdata_nx = rdata_sel;
                    m_ready_nx = 1'b1;
                    state_nx   = RESP;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    err_addr_nx  = m_addr;
                    m_ready_nx   = 1'b1;
                    m_rdata_nx   = ERR_RDATA;
                    err_pulse_nx = 1'b1;
                    err_count_nx = sat_inc(err_count);
                    state_nx     = RESP_ERR;
                end else if (!m_valid) begin
                    // Master abandoned the request: drop it silently.
                    state_nx = IDLE;
                end else begin
                    s_valid_nx = sel;
                    to_cnt_nx  = TO_EN ? to_cnt + CNT_W'(1) : '0;
                end
            end
            RESP:     state_nx = IDLE;
            RESP_ERR: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            s_valid   <= '0;
            m_ready   <= 1'b0;
            m_rdata   <= '0;
            err_pulse <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            s_valid   <= s_valid_nx;
            m_ready   <= m_ready_nx;
            m_rdata   <= m_rdata_nx;
            err_pulse <= err_pulse_nx;
            err_addr  <= err_addr_nx;
            err_count <= err_count_nx;
            to_cnt    <= to_cnt_nx;
        end
    end

endmodule

// File: tb/tb_picomem_xbar.sv
// tb_picomem_xbar: self-checking bench for picomem_xbar (4 slaves, timeout 8).
module tb_picomem_xbar;

    localparam int  N     = 4;
    localparam time CLK_P = 10;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            m_valid = 1'b0;
    logic [31:0]     m_addr  = '0;
    logic [31:0]     m_wdata = '0;
    logic [3:0]      m_wstrb = '0;
    logic            m_ready;
    logic [31:0]     m_rdata;
    logic [N-1:0]    s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [N-1:0]    s_ready = '0;
    logic [N*32-1:0] s_rdata = '0;
    logic            err_pulse;
    logic [31:0]     err_addr;
    logic [7:0]      err_count;

    picomem_xbar #(
        .N_SLAVES       (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_pulse (err_pulse),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #(CLK_P/2) clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   wt[N];          // extra wait cycles before a slave pulses ready (-1 = never)
    bit   lvl[N];         // slave ready held permanently high
    int   scnt[N];
    int   exp_ec = 0;     // bench model of err_count
    time  txn_ready_t;

    // Slave models, driven away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (lvl[i]) begin
                s_ready[i] = 1'b1;
            end else if (s_valid[i] === 1'b1) begin
                s_ready[i] = (scnt[i] == wt[i]);
                scnt[i]++;
            end else begin
                s_ready[i] = 1'b0;
                scnt[i]    = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each m_ready.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_m_ready: got m_ready=1 at %0t, want no response", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (m_rdata !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL resp_rdata: got %h, want %h", m_rdata, mon_e.rdata);
                    end
                    checks++;
                    if (err_pulse !== mon_e.err) begin
                        errors++;
                        $display("FAIL resp_err_pulse: got %b, want %b", err_pulse, mon_e.err);
                    end
                end
            end else begin
                checks++;
                if (err_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_err_pulse: got %b without m_ready, want 0", err_pulse);
                end
            end
        end
    end

    function automatic logic [31:0] sdata(input int i);
        logic [N*32-1:0] v;
        v = s_rdata;
        return v[32*i +: 32];
    endfunction

    // One master transaction; latency counted from the cycle m_valid is first sampled.
    task automatic master_txn(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                              input bit exp_err, input logic [3:0] exp_sel,
                              input int exp_lat, input string tag);
        exp_t e;
        int   cyc;
        int   sv_cyc;
        bit   done;
        bit   first;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        cyc = 0; sv_cyc = 0; done = 1'b0; first = 1'b1;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (s_valid !== 4'b0000) begin
                sv_cyc++;
                checks++;
                if (s_valid !== exp_sel) begin
                    errors++;
                    $display("FAIL %s s_valid: got %b, want %b", tag, s_valid, exp_sel);
                end
                if (first) begin
                    first = 1'b0;
                    checks++;
                    if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb) begin
                        errors++;
                        $display("FAIL %s broadcast: got %h/%h/%b, want %h/%h/%b",
                                 tag, s_addr, s_wdata, s_wstrb, addr, wdata, wstrb);
                    end
                end
            end
            if (m_ready === 1'b1) begin
                done = 1'b1;
                txn_ready_t = $time;
            end
        end
        m_valid = 1'b0;
        checks++;
        if (!done || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (done=%0b), want %0d", tag, cyc, done, exp_lat);
            if (!done && sb_q.size() > 0) void'(sb_q.pop_back());
        end
        checks++;
        if (sv_cyc != exp_lat - 1) begin
            errors++;
            $display("FAIL %s s_valid_cycles: got %0d, want %0d", tag, sv_cyc, exp_lat - 1);
        end
        @(negedge clk);
    endtask

    task automatic check_err_regs(input logic [31:0] exp_addr, input string tag);
        checks++;
        if (err_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s err_addr: got %h, want %h", tag, err_addr, exp_addr);
        end
        checks++;
        if (err_count !== 8'(exp_ec)) begin
            errors++;
            $display("FAIL %s err_count: got %0d, want %0d", tag, err_count, exp_ec);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_valid !== 4'b0 || m_ready !== 1'b0 || m_rdata !== 32'h0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got s_valid=%b m_ready=%b m_rdata=%h err_pulse=%b, want 0",
                     s_valid, m_ready, m_rdata, err_pulse);
        end
        check_err_regs(32'h0, "reset");
        reset = 1'b0;
    endtask

    task automatic test_read();
        wt[0] = 0;
        master_txn(32'h0000_0010, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 4'b0001, 2, "read_s0");
        check_err_regs(32'h0, "read_s0");
    endtask

    task automatic test_write();
        wt[2] = 1;
        master_txn(32'h0200_0000, 32'h0000_003F, 4'b0001, sdata(2), 1'b0, 4'b0100, 3, "write_s2");
        check_err_regs(32'h0, "write_s2");
    endtask

    task automatic test_unselected_ready();
        lvl[2] = 1'b1;
        wt[0]  = 2;
        master_txn(32'h0000_0100, 32'h0, 4'b0000, sdata(0), 1'b0, 4'b0001, 4, "unsel_ready");
        lvl[2] = 1'b0;
        wt[0]  = 0;
    endtask

    task automatic test_level_ready();
        lvl[1] = 1'b1;
        master_txn(32'h0000_2004, 32'h0, 4'b0000, sdata(1), 1'b0, 4'b0010, 2, "level_ready");
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (m_ready !== 1'b0 || s_valid !== 4'b0) begin
                errors++;
                $display("FAIL level_ready_idle: got m_ready=%b s_valid=%b, want 0/0", m_ready, s_valid);
            end
        end
        lvl[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unmapped();
        master_txn(32'h0300_0000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 4'b0000, 1, "unmapped_rd");
        exp_ec++;
        check_err_regs(32'h0300_0000, "unmapped_rd");
        master_txn(32'h0300_0040, 32'hFFFF_FFFF, 4'b1111, 32'hDEAD_BEEF, 1'b1, 4'b0000, 1, "unmapped_wr");
        exp_ec++;
        check_err_regs(32'h0300_0040, "unmapped_wr");
    endtask

    task automatic test_timeout();
        wt[3] = -1;
        master_txn(32'h0200_4000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 4'b1000, 9, "timeout");
        exp_ec++;
        check_err_regs(32'h0200_4000, "timeout");
        wt[3] = 0;
    endtask

    task automatic test_master_abort();
        wt[0] = -1;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0000_0020;
        m_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_valid !== 4'b0 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: got s_valid=%b m_ready=%b, want 0/0", s_valid, m_ready);
        end
        repeat (10) @(negedge clk);
        check_err_regs(32'h0200_4000, "abort");
        wt[0] = 0;
    endtask

    task automatic test_reset_mid();
        wt[1] = -1;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0000_2004;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_valid !== 4'b0 || m_ready !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got s_valid=%b m_ready=%b err_pulse=%b, want 0",
                     s_valid, m_ready, err_pulse);
        end
        exp_ec = 0;
        check_err_regs(32'h0, "reset_mid");
        @(negedge clk);
        reset = 1'b0;
        wt[1] = 0;
        master_txn(32'h0000_2004, 32'h0, 4'b0000, sdata(1), 1'b0, 4'b0010, 2, "after_reset");
    endtask

    task automatic test_back_to_back();
        time t0;
        time t1;
        wt[0] = 0; wt[1] = 0; wt[2] = 0;
        master_txn(32'h0000_0004, 32'h0, 4'b0000, sdata(0), 1'b0, 4'b0001, 2, "b2b_0");
        t0 = txn_ready_t;
        master_txn(32'h0000_2008, 32'h0, 4'b0000, sdata(1), 1'b0, 4'b0010, 2, "b2b_1");
        t1 = txn_ready_t;
        checks++;
        if (t1 - t0 != 3 * CLK_P) begin
            errors++;
            $display("FAIL b2b_period_a: got %0t, want %0t", t1 - t0, 3 * CLK_P);
        end
        master_txn(32'h0200_0003, 32'h0, 4'b0000, sdata(2), 1'b0, 4'b0100, 2, "b2b_2");
        checks++;
        if (txn_ready_t - t1 != 3 * CLK_P) begin
            errors++;
            $display("FAIL b2b_period_b: got %0t, want %0t", txn_ready_t - t1, 3 * CLK_P);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            a = 32'h0400_0000 + 32'(i);
            master_txn(a, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 4'b0000, 1, "saturate");
            if (exp_ec < 255) exp_ec++;
            check_err_regs(a, "saturate");
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL saturate_final: got %0d, want 255", err_count);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            wt[i] = 0; lvl[i] = 1'b0; scnt[i] = 0;
        end
        s_rdata = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'h1234_5678};
        test_reset();
        test_read();
        test_write();
        test_unselected_ready();
        test_level_ready();
        test_unmapped();
        test_timeout();
        test_master_abort();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_responses: got %0d pending, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: got no end of test by %0t, want completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/picomem_xbar.md
Name: picomem_xbar

Overview:
Parametrised 1-master / N-slave interconnect for the picorv32 native memory bus. Replaces hand-written per-peripheral ready/rdata muxing in SoC tops. Provides a registered address decode from a per-slave base/mask table and a single outstanding transaction. Returns an error response with a latched fault address on unmapped accesses or slave timeout.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
SLV_BASE, {32'h0200_4000,32'h0200_0000,32'h0000_2000,32'h0000_0000}, packed N_SLAVES*32 base table, slave i at [32*i+:32]
SLV_MASK, {32'hFFFF_FFF0,32'hFFFF_FFFC,32'hFFFF_FC00,32'hFFFF_E000}, packed N_SLAVES*32 mask table; slave i matches when (m_addr & mask_i) == base_i
TIMEOUT_CYCLES, 255, max ACCESS cycles before error; 0 disables timeout
ERR_RDATA, 32'hDEAD_BEEF, m_rdata value returned on any error response

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_valid  in  1  master request valid; held until m_ready
m_addr  in  32  master byte address
m_wdata  in  32  master write data
m_wstrb  in  4  byte strobes; 0 = read
m_ready  out  1  one-cycle completion pulse to master
m_rdata  out  32  read data, valid while m_ready=1
s_valid  out  N_SLAVES  one-hot request to selected slave
s_addr  out  32  broadcast address (= m_addr, combinational)
s_wdata  out  32  broadcast write data (= m_wdata)
s_wstrb  out  4  broadcast strobes (= m_wstrb)
s_ready  in  N_SLAVES  per-slave completion (pulse or level)
s_rdata  in  N_SLAVES*32  per-slave read data, slave i at [32*i+:32]
err_pulse  out  1  one-cycle pulse on each error response (usable as an IRQ line)
err_addr  out  32  address of the most recent faulting access
err_count  out  8  saturating error count

Behaviour:
- Reset values: state=IDLE, s_valid=0, m_ready=0, m_rdata=0, err_pulse=0, err_addr=0, err_count=0, timeout counter=0.
- A reset asserted mid-transaction aborts it. On the next edge, outputs take their reset values with no m_ready.
- FSM IDLE:
  - m_valid=1 with a match: register one-hot sel, where the lowest index wins on overlapping windows. Go to ACCESS.
  - m_valid=1 with no match: latch err_addr=m_addr and go to RESP_ERR.
- FSM ACCESS:
  - s_valid = sel. Timeout counter increments each cycle.
  - Only s_ready & sel is sampled; s_ready from unselected slaves is ignored.
  - s_ready[sel]=1: capture s_rdata[sel] into m_rdata (captured for writes too) and go to RESP.
  - Otherwise, counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): latch err_addr and go to RESP_ERR.
  - s_ready in the same cycle the timeout would fire: the slave response wins.
  - m_valid drops (protocol violation): deassert s_valid and return to IDLE with no m_ready.
- FSM RESP: m_ready=1 for exactly one cycle, s_valid=0, then IDLE.
- FSM RESP_ERR: m_ready=1, m_rdata=ERR_RDATA, err_pulse=1, err_count+=1 saturating at 255, then IDLE.
- Writes to unmapped space are dropped; no slave sees s_valid.
- Latency: m_valid at cycle 0 and slave ready at cycle k (k≥1) give m_ready at cycle k+1. An unmapped access gives m_ready at cycle 1.
- Back-to-back: a new m_valid is accepted in IDLE the cycle after RESP, so the minimum transaction period is 3 cycles.
- A level-type s_ready held high into RESP/IDLE does not complete a second transaction, because s_valid is already low.

Decomposition:
- Package picomem_pkg holds:
  - state enum {IDLE, ACCESS, RESP, RESP_ERR}
  - default ERR_RDATA constant
  - width constants ADDR_W=32, DATA_W=32, STRB_W=4
- One sub-module, picomem_addr_decode: combinational priority matcher. Takes m_addr, SLV_BASE and SLV_MASK; outputs one-hot hit[N_SLAVES] and a no_match flag.

Test Plan:
- Read 0x0000_0010 with slave0 ready 1 cycle after s_valid, s_rdata0=0x1234_5678 -> s_valid=4'b0001 at cycle 1, m_ready at cycle 2 with m_rdata=0x1234_5678, err_pulse=0.
- Write 0x0200_0000, wdata=0x3F, wstrb=4'b0001 -> only s_valid[2] asserted, s_wstrb=4'b0001, single m_ready pulse, err_count unchanged.
- Read 0x0300_0000 (unmapped) -> no s_valid, m_ready at cycle 1 with m_rdata=0xDEAD_BEEF, err_pulse=1, err_addr=0x0300_0000, err_count=1.
- Access 0x0200_4000 with s_ready3 held low, TIMEOUT_CYCLES=8 -> s_valid[3] high for 8 cycles then low, m_ready with 0xDEAD_BEEF, err_addr=0x0200_4000.
- Assert reset while in ACCESS on slave1 -> next cycle s_valid=0, m_ready=0, err_count=0; a subsequent read of 0x0000_2004 completes normally.
- 300 consecutive unmapped reads -> err_count saturates at 255; each access still gets exactly one m_ready and one err_pulse.
